// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: registered PC toward a falling-edge-sampled instruction memory,
// IF/ID register, halt/resume control and a saturating delivered-instruction counter.
module unidad_busqueda #(
  parameter int          ANCHO_DIR  = 10,
  parameter int          ANCHO_CONT = 16,
  parameter logic [31:0] INSTR_HLT  = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  salto_valido,
  input  logic [ANCHO_DIR-1:0]  salto_destino,
  input  logic                  reanudar,
  input  logic [31:0]           instr_mem,
  output logic [ANCHO_DIR-1:0]  direccion,
  output logic [31:0]           instruccion,
  output logic [ANCHO_DIR-1:0]  pc_mas_uno,
  output logic                  valida,
  output logic                  detenido,
  output logic [ANCHO_CONT-1:0] contador_instr
);

  typedef enum logic {EJECUTA, ALTO} estado_t;

  estado_t               estado_reg, estado_next;
  logic [ANCHO_DIR-1:0]  direccion_reg, direccion_next;
  logic [31:0]           instruccion_reg, instruccion_next;
  logic [ANCHO_DIR-1:0]  pc_mas_uno_reg, pc_mas_uno_next;
  logic                  valida_reg, valida_next;
  logic                  detenido_reg, detenido_next;
  logic [ANCHO_CONT-1:0] contador_reg, contador_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg      <= EJECUTA;
      direccion_reg   <= '0;
      instruccion_reg <= INSTR_HLT;
      pc_mas_uno_reg  <= '0;
      valida_reg      <= 1'b0;
      detenido_reg    <= 1'b0;
      contador_reg    <= '0;
    end else begin
      estado_reg      <= estado_next;
      direccion_reg   <= direccion_next;
      instruccion_reg <= instruccion_next;
      pc_mas_uno_reg  <= pc_mas_uno_next;
      valida_reg      <= valida_next;
      detenido_reg    <= detenido_next;
      contador_reg    <= contador_next;
    end
  end

  always_comb begin
    estado_next      = estado_reg;
    direccion_next   = direccion_reg;
    instruccion_next = instruccion_reg;
    pc_mas_uno_next  = pc_mas_uno_reg;
    valida_next      = valida_reg;
    contador_next    = contador_reg;

    if (salto_valido) begin
      // Redirect wins over stall and halt; the word already in flight is squashed.
      direccion_next   = salto_destino;
      instruccion_next = INSTR_HLT;
      valida_next      = 1'b0;
      estado_next      = EJECUTA;
    end else if (estado_reg == ALTO) begin
      instruccion_next = INSTR_HLT;
      valida_next      = 1'b0;
      if (reanudar) begin
        direccion_next = direccion_reg + 1'b1;
        estado_next    = EJECUTA;
      end
    end else if (stall) begin
      estado_next = estado_reg;
    end else if (instr_mem == INSTR_HLT) begin
      instruccion_next = INSTR_HLT;
      valida_next      = 1'b0;
      estado_next      = ALTO;
    end else begin
      instruccion_next = instr_mem;
      pc_mas_uno_next  = direccion_reg + 1'b1;
      valida_next      = 1'b1;
      direccion_next   = direccion_reg + 1'b1;
      if (contador_reg != '1)
        contador_next = contador_reg + 1'b1;
    end

    detenido_next = (estado_next == ALTO);
  end

  assign direccion      = direccion_reg;
  assign instruccion    = instruccion_reg;
  assign pc_mas_uno     = pc_mas_uno_reg;
  assign valida         = valida_reg;
  assign detenido       = detenido_reg;
  assign contador_instr = contador_reg;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Scoreboard bench for unidad_busqueda: a cycle model pushes expected outputs per step,
// which are popped and compared one edge later; a narrow-counter twin exercises saturation.
module tb_unidad_busqueda;

  localparam int          AD  = 10;
  localparam logic [31:0] HLT = 32'h00000000;

  logic          clk;
  logic          reset, stall, salto_valido, reanudar;
  logic [AD-1:0] salto_destino;
  logic [31:0]   instr_mem;
  logic [AD-1:0] direccion, pc_mas_uno, direccion_s, pc_mas_uno_s;
  logic [31:0]   instruccion, instruccion_s;
  logic          valida, detenido, valida_s, detenido_s;
  logic [15:0]   contador_instr;
  logic [2:0]    contador_s;

  logic [31:0] rom [1024];

  unidad_busqueda #(.ANCHO_DIR(AD), .ANCHO_CONT(16), .INSTR_HLT(HLT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .salto_valido(salto_valido),
    .salto_destino(salto_destino), .reanudar(reanudar), .instr_mem(instr_mem),
    .direccion(direccion), .instruccion(instruccion), .pc_mas_uno(pc_mas_uno),
    .valida(valida), .detenido(detenido), .contador_instr(contador_instr)
  );

  // Same stimulus, 3-bit counter so saturation is reached in a short run.
  unidad_busqueda #(.ANCHO_DIR(AD), .ANCHO_CONT(3), .INSTR_HLT(HLT)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .salto_valido(salto_valido),
    .salto_destino(salto_destino), .reanudar(reanudar), .instr_mem(instr_mem),
    .direccion(direccion_s), .instruccion(instruccion_s), .pc_mas_uno(pc_mas_uno_s),
    .valida(valida_s), .detenido(detenido_s), .contador_instr(contador_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) instr_mem <= rom[direccion];

  typedef struct {
    logic [AD-1:0] dir;
    logic [31:0]   ins;
    logic [AD-1:0] pc1;
    logic          val;
    logic          det;
    logic [15:0]   cnt;
    logic [2:0]    cnt_s;
  } esperado_t;

  esperado_t cola[$];
  int total = 0;
  int bad   = 0;

  logic [AD-1:0] m_dir = '0;
  logic [31:0]   m_ins = HLT;
  logic [AD-1:0] m_pc1 = '0;
  logic          m_val = 1'b0;
  logic          m_alto = 1'b0;
  int            m_cnt = 0;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelo(input logic r, st, sv, input logic [AD-1:0] sd, input logic re);
    if (r) begin
      m_dir = '0; m_ins = HLT; m_pc1 = '0; m_val = 1'b0; m_alto = 1'b0; m_cnt = 0;
    end else if (sv) begin
      m_dir = sd; m_ins = HLT; m_val = 1'b0; m_alto = 1'b0;
    end else if (m_alto) begin
      if (re) begin
        m_dir = m_dir + 1'b1;
        m_alto = 1'b0;
      end
    end else if (!st) begin
      if (rom[m_dir] == HLT) begin
        m_ins = HLT; m_val = 1'b0; m_alto = 1'b1;
      end else begin
        m_ins = rom[m_dir];
        m_dir = m_dir + 1'b1;
        m_pc1 = m_dir;
        m_val = 1'b1;
        m_cnt++;
      end
    end
  endtask

  task automatic paso(input logic r, st, sv, input logic [AD-1:0] sd, input logic re);
    esperado_t e;
    reset = r; stall = st; salto_valido = sv; salto_destino = sd; reanudar = re;
    modelo(r, st, sv, sd, re);
    e.dir = m_dir; e.ins = m_ins; e.pc1 = m_pc1; e.val = m_val; e.det = m_alto;
    e.cnt = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt_s = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
    cola.push_back(e);
    @(posedge clk);
    #1;
    if (cola.size() == 0) begin
      chequear("cola_vacia", 32'd0, 32'd1);
    end else begin
      e = cola.pop_front();
      chequear("direccion", 32'(direccion), 32'(e.dir));
      chequear("instruccion", instruccion, e.ins);
      chequear("pc_mas_uno", 32'(pc_mas_uno), 32'(e.pc1));
      chequear("valida", 32'(valida), 32'(e.val));
      chequear("detenido", 32'(detenido), 32'(e.det));
      chequear("contador", 32'(contador_instr), 32'(e.cnt));
      chequear("contador_sat", 32'(contador_s), 32'(e.cnt_s));
    end
    $display("t=%0t r=%b st=%b sv=%b sd=%0d re=%b | dir=%0d ins=%h pc1=%0d val=%b det=%b cnt=%0d sat=%0d",
             $time, r, st, sv, sd, re, direccion, instruccion, pc_mas_uno, valida, detenido,
             contador_instr, contador_s);
  endtask

  task automatic corre(input int n);
    for (int i = 0; i < n; i++) paso(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; salto_valido = 1'b0; salto_destino = '0; reanudar = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = HLT;
    rom[0] = 32'h8C010001; rom[1] = 32'h00211020; rom[2] = 32'h00441820;
    rom[3] = 32'h00622020; rom[4] = HLT;

    // Straight-line program up to HLT, then idle in ALTO
    paso(1'b1, 1'b0, 1'b0, '0, 1'b0);
    paso(1'b1, 1'b0, 1'b0, '0, 1'b0);
    corre(7);
    // Stall in ALTO is ignored, reanudar with a 1-cycle pulse after loading rom[5]
    rom[5] = 32'h00211020; rom[6] = HLT;
    paso(1'b0, 1'b1, 1'b0, '0, 1'b0);
    paso(1'b0, 1'b0, 1'b0, '0, 1'b1);
    corre(3);

    // Stall on edges 2-3
    paso(1'b1, 1'b0, 1'b0, '0, 1'b0);
    paso(1'b0, 1'b0, 1'b0, '0, 1'b0);
    paso(1'b0, 1'b1, 1'b0, '0, 1'b0);
    paso(1'b0, 1'b1, 1'b0, '0, 1'b0);
    corre(4);

    // Branch with stall at edge 2; reanudar while fetching is ignored
    paso(1'b1, 1'b0, 1'b0, '0, 1'b0);
    paso(1'b0, 1'b0, 1'b0, '0, 1'b1);
    paso(1'b0, 1'b1, 1'b1, 10'd3, 1'b0);
    corre(3);

    // Wrap from 1023 to 0
    rom[1023] = 32'h00211020; rom[0] = 32'h00441820;
    paso(1'b0, 1'b0, 1'b1, 10'd1023, 1'b0);
    corre(7);
    rom[0] = 32'h8C010001;

    // Repeated loops without reset to push the counters past saturation
    for (int k = 0; k < 3; k++) begin
      paso(1'b0, 1'b0, 1'b1, 10'd0, 1'b0);
      corre(6);
    end

    // Randomised mix of stall/salto/reanudar
    for (int i = 0; i < 60; i++) begin
      logic [AD-1:0] d;
      d = ($urandom_range(0, 1) == 0) ? AD'($urandom_range(0, 6)) : AD'($urandom_range(1020, 1023));
      paso(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), d,
           ($urandom_range(0, 2) == 0));
    end

    // Reset mid-run together with salto and stall
    corre(1);
    paso(1'b1, 1'b1, 1'b1, 10'd7, 1'b1);
    corre(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
